dmi_target: RTL and testbench



---
 rtl/dm_pkg.sv | 33 +++
 rtl/dmi_target.sv | 131 +++++++++++++
 tb/tb_dmi_target.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Debug-module package slice: DMI request/response types and the DMI target's
// FSM state and counter address.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [6:0] DmiTargetCntAddr = 7'h7F;

  typedef enum logic [1:0] {
    Idle,
    Wait,
    Resp
  } dmi_target_state_e;

endpackage

// File: rtl/dmi_target.sv
// DMI responder backed by a bank of 32-bit scratch registers, one transaction
// in flight. Define DMI_TARGET_ACCESS_CNT_EN to add an access counter at 7'h7F.
module dmi_target
  import dm::*;
#(
  parameter int unsigned NrRegs      = 16,
  parameter logic [6:0]  BaseAddr    = 7'h04,
  parameter int unsigned RespLatency = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [$bits(dmi_req_t)-1:0]   dmi_req_i,
  input  logic                          dmi_req_valid_i,
  output logic                          dmi_req_ready_o,
  output logic [$bits(dmi_resp_t)-1:0]  dmi_resp_o,
  output logic                          dmi_resp_valid_o,
  input  logic                          dmi_resp_ready_i,
  output logic [NrRegs*32-1:0]          regs_o
);

  localparam int unsigned IdxW = (NrRegs > 1) ? $clog2(NrRegs) : 1;

  dmi_target_state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  dmi_resp_t         resp_q, resp_d;
  logic [31:0]       regs_q [NrRegs];
  logic [31:0]       regs_d [NrRegs];

  dmi_req_t          req;
  logic              req_fire;
  logic              in_range;
  logic [IdxW-1:0]   idx;
  logic              cnt_hit;
  logic [31:0]       acc_val;

  assign req      = dmi_req_t'(dmi_req_i);
  assign req_fire = (state_q == Idle) && dmi_req_valid_i;

  // Zero-extend to 8 bits so BaseAddr+NrRegs past 7'h7F does not wrap.
  assign in_range = ({1'b0, req.addr} >= {1'b0, BaseAddr}) &&
                    ({1'b0, req.addr} <  ({1'b0, BaseAddr} + 8'(NrRegs)));
  assign idx      = IdxW'(req.addr - BaseAddr);

`ifdef DMI_TARGET_ACCESS_CNT_EN
  logic [31:0] acc_cnt_q, acc_cnt_d;

  assign cnt_hit   = (req.addr == DmiTargetCntAddr);
  assign acc_val   = acc_cnt_q;
  assign acc_cnt_d = req_fire ? acc_cnt_q + 32'd1 : acc_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) acc_cnt_q <= '0;
    else         acc_cnt_q <= acc_cnt_d;
  end
`else
  assign cnt_hit = 1'b0;
  assign acc_val = '0;
`endif

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    regs_d  = regs_q;

    unique case (state_q)
      Idle: begin
        if (dmi_req_valid_i) begin
          resp_d = '{data: '0, resp: DTM_ERR};
          case (req.op)
            DTM_NOP: resp_d.resp = DTM_SUCCESS;
            DTM_READ: begin
              if (cnt_hit) begin
                resp_d = '{data: acc_val, resp: DTM_SUCCESS};
              end else if (in_range) begin
                resp_d = '{data: regs_q[idx], resp: DTM_SUCCESS};
              end
            end
            DTM_WRITE: begin
              if (in_range && !cnt_hit) begin
                regs_d[idx] = req.data;
                resp_d      = '{data: req.data, resp: DTM_SUCCESS};
              end
            end
            default: ;
          endcase
          cnt_d   = 4'(RespLatency);
          state_d = (RespLatency > 0) ? Wait : Resp;
        end
      end
      Wait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = Resp;
      end
      Resp: begin
        if (dmi_resp_ready_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  // NOTE: sequential state is only written here and only with <=, so every
  // flop samples the settled combinational value of the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Idle;
      cnt_q   <= '0;
      resp_q  <= '0;
      // NOTE: the bank is ordinary flops that must read as zero after reset,
      // so it is cleared here like the rest of the state.
      for (int i = 0; i < NrRegs; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      regs_q  <= regs_d;
    end
  end

  // Handshake outputs are held low while reset is asserted.
  assign dmi_req_ready_o  = rst_ni && (state_q == Idle);
  assign dmi_resp_valid_o = rst_ni && (state_q == Resp);
  assign dmi_resp_o       = resp_q;

  for (genvar i = 0; i < NrRegs; i++) begin : g_regs_o
    assign regs_o[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_dmi_target.sv
// Scoreboard bench for dmi_target: expected responses are queued at request
// time and compared by a monitor on each response handshake.
`timescale 1ns/1ps
module tb_dmi_target;
  import dm::*;

  localparam int unsigned NR   = 16;
  localparam logic [6:0]  BASE = 7'h04;
  localparam int unsigned LAT  = 3;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  dmi_req_t                      req_s;
  logic                          req_valid = 1'b0;
  logic                          req_ready;
  logic [$bits(dmi_resp_t)-1:0]  resp_bits;
  dmi_resp_t                     resp_s;
  logic                          resp_valid;
  logic                          resp_ready = 1'b1;
  logic [NR*32-1:0]              regs;

  int        errors = 0;
  int        checks = 0;
  int        rx_cnt = 0;
  dmi_resp_t exp_q[$];
  logic [31:0] model [NR];

  assign resp_s = dmi_resp_t'(resp_bits);

  always #5 clk = ~clk;

  dmi_target #(.NrRegs(NR), .BaseAddr(BASE), .RespLatency(LAT)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .dmi_req_i        (req_s),
    .dmi_req_valid_i  (req_valid),
    .dmi_req_ready_o  (req_ready),
    .dmi_resp_o       (resp_bits),
    .dmi_resp_valid_o (resp_valid),
    .dmi_resp_ready_i (resp_ready),
    .regs_o           (regs)
  );

  // Response monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got data=%h resp=%h, expected no response", resp_s.data, resp_s.resp);
      end else begin
        dmi_resp_t e;
        e = exp_q.pop_front();
        rx_cnt++;
        if (resp_s !== e) begin
          errors++;
          $display("FAIL resp: got data=%h resp=%h, expected data=%h resp=%h", resp_s.data, resp_s.resp, e.data, e.resp);
        end
      end
    end
  end

  function automatic logic [NR*32-1:0] pack_model();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // Issue one request (entered and left at posedge+1) and queue its expected response.
  task automatic send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                      input logic [31:0] ed, input logic [1:0] er);
    int n;
    n = 0;
    req_s     = '{addr: a, op: dtm_op_e'(op), data: d};
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: addr=%h ready=%b after %0d cycles, expected 1", a, req_ready, n);
    end else begin
      exp_q.push_back('{data: ed, resp: er});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d after %0d cycles, expected 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic check_regs(input string name);
    checks++;
    if (regs !== pack_model()) begin
      errors++;
      $display("FAIL %s: regs_o=%h expected %h", name, regs, pack_model());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    if (resp_bits !== '0) begin errors++; $display("FAIL rst_resp: got %h expected 0", resp_bits); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", resp_valid); end
    check_regs("post_rst_regs");
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    send(7'h04, DTM_WRITE, 32'hDEADBEEF, 32'hDEADBEEF, DTM_SUCCESS);
    model[0] = 32'hDEADBEEF;
    send(7'h04, DTM_READ, 32'h0, 32'hDEADBEEF, DTM_SUCCESS);
    drain();
    check_regs("write_read_regs");
  endtask

  task automatic test_out_of_range();
    send(7'h03, DTM_READ, 32'h0, 32'h0, DTM_ERR);
    send(7'h14, DTM_READ, 32'h0, 32'h0, DTM_ERR);
    send(7'h14, DTM_WRITE, 32'h1, 32'h0, DTM_ERR);
    send(7'h13, DTM_WRITE, 32'hA5A5_0013, 32'hA5A5_0013, DTM_SUCCESS);
    model[15] = 32'hA5A5_0013;
    send(7'h05, DTM_NOP, 32'hFFFF_FFFF, 32'h0, DTM_SUCCESS);
    send(7'h05, 2'h3, 32'h1234_5678, 32'h0, DTM_ERR);
`ifndef DMI_TARGET_ACCESS_CNT_EN
    send(7'h7F, DTM_READ, 32'h0, 32'h0, DTM_ERR);
`endif
    drain();
    check_regs("out_of_range_regs");
  endtask

  task automatic test_latency_stall();
    dmi_resp_t e;
    e = '{data: model[0], resp: DTM_SUCCESS};
    resp_ready = 1'b0;
    req_s      = '{addr: 7'h04, op: DTM_READ, data: 32'h0};
    req_valid  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL lat_accept: ready=%b expected 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (resp_valid !== (k == 4)) begin errors++; $display("FAIL lat_valid_%0d: got %b expected %b", k, resp_valid, (k == 4)); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_%0d: got %b expected 0", k, req_ready); end
    end
    // A request presented while busy must be ignored entirely.
    @(posedge clk);
    #1;
    req_s     = '{addr: 7'h06, op: DTM_WRITE, data: 32'h0000_0BAD};
    req_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checks += 3;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 1", s, resp_valid); end
      if (resp_s !== e) begin errors++; $display("FAIL stall_data_%0d: got %h expected %h", s, resp_s, e); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b expected 0", s, req_ready); end
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL hs_cycle_ready: got %b expected 0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL after_hs_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL after_hs_valid: got %b expected 0", resp_valid); end
    check_regs("stall_ignored_regs");
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_reset_mid_op();
    logic saw_valid;
    saw_valid = 1'b0;
    req_s     = '{addr: 7'h05, op: DTM_WRITE, data: 32'h55};
    req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_accept: ready=%b expected 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", req_ready); end
    check_regs("mid_rst_regs");
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_spurious: resp_valid seen=%b expected 0", saw_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int rx0;
    rx0 = rx_cnt;
    resp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      send(7'(BASE + i), DTM_WRITE, 32'(i + 1), 32'(i + 1), DTM_SUCCESS);
      model[i] = 32'(i + 1);
    end
    for (int i = 0; i < NR; i++) send(7'(BASE + i), DTM_READ, 32'h0, 32'(i + 1), DTM_SUCCESS);
    drain();
    checks++;
    if (rx_cnt - rx0 !== 2 * NR) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", rx_cnt - rx0, 2 * NR); end
    check_regs("b2b_regs");
  endtask

`ifdef DMI_TARGET_ACCESS_CNT_EN
  task automatic test_access_cnt();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    send(7'h04, DTM_NOP, 32'h0, 32'h0, DTM_SUCCESS);
    send(7'h04, DTM_READ, 32'h0, 32'h0, DTM_SUCCESS);
    send(7'h03, DTM_READ, 32'h0, 32'h0, DTM_ERR);
    send(DmiTargetCntAddr, DTM_READ, 32'h0, 32'd3, DTM_SUCCESS);
    send(DmiTargetCntAddr, DTM_WRITE, 32'h123, 32'h0, DTM_ERR);
    send(DmiTargetCntAddr, DTM_READ, 32'h0, 32'd5, DTM_SUCCESS);
    drain();
    check_regs("cnt_regs");
  endtask
`endif

  initial begin
    req_s = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_latency_stall();
    test_reset_mid_op();
    test_back_to_back();
`ifdef DMI_TARGET_ACCESS_CNT_EN
    test_access_cnt();
`endif
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
